// File: rtl/vending_machine.sv
// Coin-accumulating vending controller: sums 1/2/5 rupee strobes into a credit
// register, pulses dispense when credit reaches PRICE and keeps the excess.
module vending_machine #(
  parameter int unsigned PRICE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rupee1,
  input  logic       rupee2,
  input  logic       rupee5,
  output logic       dispense,
  output logic [3:0] state
);

  localparam logic [4:0] PRICE_W = 5'(PRICE);

  // Simultaneous strobes are treated as a rejected coin worth nothing.
  function automatic logic [2:0] coin_value(input logic r1, input logic r2, input logic r5);
    logic [2:0] val;
    case ({r5, r2, r1})
      3'b001:  val = 3'd1;
      3'b010:  val = 3'd2;
      3'b100:  val = 3'd5;
      default: val = 3'd0;
    endcase
    return val;
  endfunction

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       dispense_q;
  logic       dispense_d;
  logic [2:0] coin_s;
  logic [4:0] sum_s;

  // Next credit and purchase decision.
  always_comb begin
    coin_s     = coin_value(rupee1, rupee2, rupee5);
    sum_s      = {1'b0, state_q} + {2'b00, coin_s};
    state_d    = sum_s[3:0];
    dispense_d = 1'b0;
    if (sum_s >= PRICE_W) begin
      state_d    = 4'(sum_s - PRICE_W);
      dispense_d = 1'b1;
    end else begin
      state_d    = sum_s[3:0];
      dispense_d = 1'b0;
    end
  end

  // Credit and dispense registers; reset forfeits credit and cancels a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= 4'd0;
      dispense_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dispense_q <= dispense_d;
    end
  end

  assign state    = state_q;
  assign dispense = dispense_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine with PRICE=10.
module tb_vending_machine;

  logic       clk;
  logic       reset;
  logic       rupee1;
  logic       rupee2;
  logic       rupee5;
  logic       dispense;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  vending_machine #(.PRICE(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .rupee1   (rupee1),
    .rupee2   (rupee2),
    .rupee5   (rupee5),
    .dispense (dispense),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge consume them, then check outputs.
  task automatic step(input string tag, input logic rst, input logic r1, input logic r2,
                      input logic r5, input logic [3:0] exp_state, input logic exp_disp);
    reset  = rst;
    rupee1 = r1;
    rupee2 = r2;
    rupee5 = r5;
    @(posedge clk);
    #1;
    check_eq({tag, ".state"}, {4'd0, state}, {4'd0, exp_state});
    check_eq({tag, ".dispense"}, {7'd0, dispense}, {7'd0, exp_disp});
  endtask

  initial begin
    reset  = 1'b1;
    rupee1 = 1'b0;
    rupee2 = 1'b0;
    rupee5 = 1'b1;
    #2;

    // 1: reset held with a coin present
    step("rst0", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    step("rst1", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

    // 2: 5 + 5
    step("t2c1", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    step("t2c2", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    step("t2idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // 3: five 2-rupee coins
    step("t3c1", 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    step("t3c2", 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0);
    step("t3c3", 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0);
    step("t3c4", 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
    step("t3c5", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    step("t3idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // 4: 5,2,2,5 with carry-over, then 5,1
    step("t4c1", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    step("t4c2", 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);
    step("t4c3", 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
    step("t4c4", 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1);
    step("t4c5", 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    step("t4c6", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    step("t4idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // 5: reach 3, then rejected multi-strobe coins and idles
    step("t5c1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    step("t5c2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    step("t5c3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    step("t5rej15", 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    step("t5rej12", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
    step("t5rej125", 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    step("t5idle1", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    step("t5idle2", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);

    // 6: credit 8, reset with a purchase-completing coin, then restart
    step("t6c5", 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0);
    step("t6rst", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("t6c1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    step("t6idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
